// File: rtl/blink_stretcher_if.sv
// Event/LED bundle between control logic and the blink stretcher.
// The control side drives pulse_in. The stretcher reports the LED drive and its queue status.
interface blink_stretcher_if #(
    parameter int MAX_PENDING = 15
) ();
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic          pulse_in;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    modport master (
        output pulse_in,
        input  led,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output led,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/blink_stretcher.sv
// Turns single-cycle event strobes into fixed-length LED blinks separated by a forced off gap.
// Events that arrive during a blink are queued in a saturating counter, so every accepted event is shown.
module blink_stretcher #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int ON_MS       = 50,
    parameter int OFF_MS      = 50,
    parameter int MAX_PENDING = 15
) (
    input  logic            clk,
    input  logic            rst,
    blink_stretcher_if.slave bus
);
    localparam int ON_CYCLES  = (CLK_HZ / 1000) * ON_MS;
    localparam int OFF_CYCLES = (CLK_HZ / 1000) * OFF_MS;
    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam int PW         = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic          start;
    logic          inc;
    logic          dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // The timer counts down to zero, so a value of zero marks the last cycle of ON or GAP.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.pulse_in) start = 1'b1;
            end
            S_ON: begin
                if (timer_q == '0) begin
                    state_d = S_GAP;
                    timer_d = TW'(OFF_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    if (pending_q != '0 || bus.pulse_in) start = 1'b1;
                    else                                  state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_ON;
            timer_d = TW'(ON_CYCLES - 1);
        end
    end

    // A start uses the live strobe only when nothing is queued. Otherwise it drains the queue and the strobe is queued.
    always_comb begin
        dec        = start && (pending_q != '0);
        inc        = bus.pulse_in && !(start && (pending_q == '0));
        pending_d  = pending_q;
        overflow_d = 1'b0;
        if (inc && !dec) begin
            if (pending_q == PW'(MAX_PENDING)) overflow_d = 1'b1;
            else                               pending_d  = pending_q + PW'(1);
        end else if (dec && !inc) begin
            pending_d = pending_q - PW'(1);
        end
    end

    assign bus.led      = (state_q == S_ON);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_blink_stretcher.sv
// Directed checks of blink timing, queueing, saturation and reset for blink_stretcher.
// The bench uses On=3 and Off=2 cycles. Expected waveforms are hand-written per-cycle masks.
module tb_blink_stretcher;
    localparam int NCYC = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cur_cyc  = 0;

    blink_stretcher_if #(.MAX_PENDING(2)) bus ();

    blink_stretcher #(
        .CLK_HZ     (1000),
        .ON_MS      (3),
        .OFF_MS     (2),
        .MAX_PENDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cur_cyc, obs, exp);
    endtask

    function automatic logic [NCYC-1:0] rng(input int lo, input int hi);
        logic [NCYC-1:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic run_test(input string tag,
                            input logic [NCYC-1:0] pm, input logic [NCYC-1:0] lm,
                            input logic [NCYC-1:0] bm, input logic [NCYC-1:0] p1m,
                            input logic [NCYC-1:0] p2m, input logic [NCYC-1:0] om,
                            input int rst_cyc, input int rst_len);
        int fails_before;
        int exp_pend;
        fails_before = n_checks - n_pass;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.pulse_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk); #1;
            cur_cyc = c;
            if (c == rst_cyc) begin
                check_eq({tag, ".pre_rst_pending"}, int'(bus.pending), 2);
                rst = 1'b1;
            end
            if (rst_cyc >= 0 && c == rst_cyc + rst_len) rst = 1'b0;
            bus.pulse_in = pm[c];
            @(negedge clk);
            exp_pend = p2m[c] ? 2 : (p1m[c] ? 1 : 0);
            check_eq({tag, ".led"},      int'(bus.led),      int'(lm[c]));
            check_eq({tag, ".busy"},     int'(bus.busy),     int'(bm[c]));
            check_eq({tag, ".pending"},  int'(bus.pending),  exp_pend);
            check_eq({tag, ".overflow"}, int'(bus.overflow), int'(om[c]));
        end
        bus.pulse_in = 1'b0;
        $display("test %s: %0d new failures, %0d checks so far", tag,
                 (n_checks - n_pass) - fails_before, n_checks);
    endtask

    initial begin
        bus.pulse_in = 1'b0;

        // Single pulse
        run_test("single", rng(10, 10), rng(11, 13), rng(11, 15),
                 '0, '0, '0, -1, 0);
        // Three back-to-back pulses queue two
        run_test("queue", rng(10, 12), rng(11, 13) | rng(16, 18) | rng(21, 23),
                 rng(11, 25), rng(12, 20), rng(13, 15), '0, -1, 0);
        // Five pulses: two dropped with overflow on cycles 14 and 15
        run_test("overflow", rng(10, 14), rng(11, 13) | rng(16, 18) | rng(21, 23),
                 rng(11, 25), rng(12, 20), rng(13, 15), rng(14, 15), -1, 0);
        // Pulse on the last gap cycle starts the next blink directly
        run_test("gap_edge", rng(10, 10) | rng(15, 15), rng(11, 13) | rng(16, 18),
                 rng(11, 20), '0, '0, '0, -1, 0);
        // Full queue plus a pulse on the last gap cycle keeps pending at 2 with no overflow
        run_test("full_sim", rng(10, 12) | rng(15, 15),
                 rng(11, 13) | rng(16, 18) | rng(21, 23) | rng(26, 28),
                 rng(11, 30), rng(12, 25), rng(13, 20), '0, -1, 0);
        // Reset during ON with pending=2 clears everything at once
        run_test("reset", rng(9, 11), rng(10, 11), rng(10, 11),
                 rng(11, 11), '0, '0, 12, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
